// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyphs {a,b,c,d,e,f,g,dp}
// with the decimal point dark, plus the all-off anode and cathode patterns.
package seg_pkg;
  localparam logic [7:0] CATH_OFF  = 8'hFF;
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  localparam logic [7:0] SEG_0 = 8'b00000011;
  localparam logic [7:0] SEG_1 = 8'b10011111;
  localparam logic [7:0] SEG_2 = 8'b00100101;
  localparam logic [7:0] SEG_3 = 8'b00001101;
  localparam logic [7:0] SEG_4 = 8'b10011001;
  localparam logic [7:0] SEG_5 = 8'b01001001;
  localparam logic [7:0] SEG_6 = 8'b01000001;
  localparam logic [7:0] SEG_7 = 8'b00011111;
  localparam logic [7:0] SEG_8 = 8'b00000001;
  localparam logic [7:0] SEG_9 = 8'b00001001;
  localparam logic [7:0] SEG_A = 8'b00010001;
  localparam logic [7:0] SEG_B = 8'b11000001;
  localparam logic [7:0] SEG_C = 8'b01100011;
  localparam logic [7:0] SEG_D = 8'b10000101;
  localparam logic [7:0] SEG_E = 8'b01100001;
  localparam logic [7:0] SEG_F = 8'b01110001;
endpackage

// File: rtl/seg_decode.sv
// Hex nibble to active-low segments {a..g}; purely combinational, zero latency,
// no flow control.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_8[7:1];
    case (nibble)
      4'h0: seg = SEG_0[7:1];
      4'h1: seg = SEG_1[7:1];
      4'h2: seg = SEG_2[7:1];
      4'h3: seg = SEG_3[7:1];
      4'h4: seg = SEG_4[7:1];
      4'h5: seg = SEG_5[7:1];
      4'h6: seg = SEG_6[7:1];
      4'h7: seg = SEG_7[7:1];
      4'h8: seg = SEG_8[7:1];
      4'h9: seg = SEG_9[7:1];
      4'hA: seg = SEG_A[7:1];
      4'hB: seg = SEG_B[7:1];
      4'hC: seg = SEG_C[7:1];
      4'hD: seg = SEG_D[7:1];
      4'hE: seg = SEG_E[7:1];
      4'hF: seg = SEG_F[7:1];
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed seven-segment scanner with frame-aligned shadow load.
// anode/cathode lag scan state by one clock; load_req is held until load_ack, which only fires at frame boundaries.
module seg_scan
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] digits,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp,
  input  logic        load_req,
  output logic        load_ack,
  output logic [7:0]  anode,
  output logic [7:0]  cathode
);

  localparam int CW = $clog2(REFRESH_DIV);

  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [31:0]   sh_digits;
  logic [7:0]    sh_en;
  logic [7:0]    sh_dp;
  logic          wrap;
  logic          boundary;
  logic          capture;
  logic          dark;
  logic [6:0]    seg;

  assign wrap     = (cnt == CW'(REFRESH_DIV - 1));
  assign boundary = wrap && (idx == 3'd7);
  assign capture  = boundary && load_req;
  assign dark     = (cnt < CW'(BLANK_CYC)) || !sh_en[idx];

  seg_decode u_decode (
    .nibble (sh_digits[{idx, 2'b00} +: 4]),
    .seg    (seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      sh_digits <= '0;
      sh_en     <= '0;
      sh_dp     <= '0;
      load_ack  <= 1'b0;
      anode     <= ANODE_OFF;
      cathode   <= CATH_OFF;
    end else begin
      cnt      <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= idx + 3'd1;
      load_ack <= capture;
      // Shadow only moves between frames so a frame never mixes old and new digits.
      if (capture) begin
        sh_digits <= digits;
        sh_en     <= digit_en;
        sh_dp     <= dp;
      end
      if (dark) begin
        anode   <= ANODE_OFF;
        cathode <= CATH_OFF;
      end else begin
        anode   <= ~(8'h01 << idx);
        cathode <= {seg, ~sh_dp[idx]};
      end
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Bench for seg_scan with REFRESH_DIV=4, BLANK_CYC=1 (32-cycle frames): a cycle-position
// display model plus an ack scoreboard check every cycle, alongside vector tables and hand sequences.
module tb_seg_scan;
  localparam int RD    = 4;
  localparam int BL    = 1;
  localparam int FRAME = 8 * RD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] digits = '0;
  logic [7:0]  digit_en = '0;
  logic [7:0]  dp = '0;
  logic        load_req = 1'b0;
  logic        load_ack;
  logic [7:0]  anode;
  logic [7:0]  cathode;

  int checks = 0;
  int failures = 0;
  int cyc;

  logic [31:0] sh_d, pr_d;
  logic [7:0]  sh_e, pr_e, sh_p, pr_p;
  int          ack_q[$];

  typedef struct {
    int         cyc;
    logic       ack;
    logic [7:0] an;
    logic [7:0] ca;
  } vec_t;
  vec_t tbl[9];

  seg_scan #(.REFRESH_DIV(RD), .BLANK_CYC(BL)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .digits   (digits),
    .digit_en (digit_en),
    .dp       (dp),
    .load_req (load_req),
    .load_ack (load_ack),
    .anode    (anode),
    .cathode  (cathode)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] glyph_on(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1111110;
      4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;
      4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;
      4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;
      4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;
      4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;
      4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;
      default: return 7'b1000111;
    endcase
  endfunction

  // Expected {anode, cathode} produced from scan state at cycle s.
  function automatic logic [15:0] exp_disp(input int s, input logic [31:0] d,
                                           input logic [7:0] en, input logic [7:0] p);
    int pos, slot, sub;
    logic [7:0] an;
    pos  = s % FRAME;
    slot = pos / RD;
    sub  = pos % RD;
    if (sub < BL || !en[slot]) return 16'hFFFF;
    an = 8'hFF;
    an[slot] = 1'b0;
    return {an, ~glyph_on(d[slot*4 +: 4]), ~p[slot]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic [15:0] e;
    @(negedge clk);
    if (!rst_n) begin
      sh_d = '0; sh_e = '0; sh_p = '0;
      pr_d = '0; pr_e = '0; pr_p = '0;
      ack_q.delete();
      chk("rst_anode", {24'h0, anode}, 32'hFF);
      chk("rst_cathode", {24'h0, cathode}, 32'hFF);
      chk("rst_ack", {31'h0, load_ack}, 32'h0);
    end else begin
      e = (cyc == 0) ? 16'hFFFF : exp_disp(cyc - 1, pr_d, pr_e, pr_p);
      chk("disp_anode", {24'h0, anode}, {24'h0, e[15:8]});
      chk("disp_cathode", {24'h0, cathode}, {24'h0, e[7:0]});
      // load_req seen here is the value sampled on the edge that closed cycle cyc-1.
      if (cyc >= FRAME && cyc % FRAME == 0 && load_req) begin
        sh_d = digits; sh_e = digit_en; sh_p = dp;
        ack_q.push_back(cyc);
      end
      if (ack_q.size() > 0 && ack_q[0] == cyc) begin
        void'(ack_q.pop_front());
        chk("ack_pulse", {31'h0, load_ack}, 32'h1);
      end else begin
        chk("ack_idle", {31'h0, load_ack}, 32'h0);
      end
      chk("one_cold", {31'h0, ($countones(~anode) <= 1)}, 32'h1);
      pr_d = sh_d; pr_e = sh_e; pr_p = sh_p;
    end
  endtask

  task automatic wait_cyc(input int n);
    int b;
    b = 0;
    while (cyc < n && b < 1000) begin
      tick();
      b++;
    end
    if (cyc != n) begin
      checks++;
      failures++;
      $display("FAIL wait_cyc actual=%0d expected=%0d", cyc, n);
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] low_an, low_ca, lowmask;
    int nacks;
    int ack_at[4];

    tbl[0] = '{32, 1'b1, 8'hFF, 8'hFF};
    tbl[1] = '{33, 1'b0, 8'hFF, 8'hFF};
    tbl[2] = '{34, 1'b0, 8'hFE, 8'b00000011};
    tbl[3] = '{36, 1'b0, 8'hFE, 8'b00000011};
    tbl[4] = '{37, 1'b0, 8'hFF, 8'hFF};
    tbl[5] = '{38, 1'b0, 8'hFD, 8'b10011111};
    tbl[6] = '{42, 1'b0, 8'hFB, 8'b00100101};
    tbl[7] = '{46, 1'b0, 8'hF7, 8'b00001101};
    tbl[8] = '{62, 1'b0, 8'h7F, 8'b00011111};

    repeat (3) tick();

    // Idle after reset: nothing may light, no ack.
    release_rst();
    low_an = '0; low_ca = '0; nacks = 0;
    repeat (41) begin
      tick();
      low_an |= ~anode;
      low_ca |= ~cathode;
      if (load_ack) nacks++;
    end
    chk("idle_anode_lit", {24'h0, low_an}, 32'h0);
    chk("idle_cathode_lit", {24'h0, low_ca}, 32'h0);
    chk("idle_acks", nacks, 0);

    // First load held from cycle 0.
    #1 rst_n = 1'b0;
    digits = 32'h76543210; digit_en = 8'hFF; dp = 8'h00; load_req = 1'b1;
    repeat (2) tick();
    release_rst();
    for (int i = 0; i < 9; i++) begin
      wait_cyc(tbl[i].cyc);
      chk("tbl_ack", {31'h0, load_ack}, {31'h0, tbl[i].ack});
      chk("tbl_anode", {24'h0, anode}, {24'h0, tbl[i].an});
      chk("tbl_cathode", {24'h0, cathode}, {24'h0, tbl[i].ca});
      if (tbl[i].cyc == 32) #1 load_req = 1'b0;
    end

    // Mid-frame input change without a request must not reach the display.
    wait_cyc(70);
    #1 digits = 32'hFEDCBA98;
    wait_cyc(80);
    chk("tear_anode", {24'h0, anode}, 32'hF7);
    chk("tear_cathode", {24'h0, cathode}, 32'h0D);
    wait_cyc(100);
    #1 load_req = 1'b1;
    wait_cyc(127);
    chk("pre_bnd_cathode", {24'h0, cathode}, 32'h1F);
    wait_cyc(128);
    chk("late_ack", {31'h0, load_ack}, 32'h1);
    #1 load_req = 1'b0;
    wait_cyc(130);
    chk("new_anode", {24'h0, anode}, 32'hFE);
    chk("new_cathode", {24'h0, cathode}, 32'h01);

    // Sparse enable with one decimal point.
    wait_cyc(131);
    #1 digit_en = 8'b00000101; dp = 8'b00000100; load_req = 1'b1;
    wait_cyc(160);
    chk("en_ack", {31'h0, load_ack}, 32'h1);
    #1 load_req = 1'b0;
    lowmask = '0;
    while (cyc < 192) begin
      tick();
      lowmask |= ~anode;
      if (cyc == 162) begin
        chk("slot0_anode", {24'h0, anode}, 32'hFE);
        chk("slot0_cathode", {24'h0, cathode}, 32'h01);
      end
      if (cyc == 166) chk("slot1_dark", {24'h0, anode}, 32'hFF);
      if (cyc == 170) begin
        chk("slot2_anode", {24'h0, anode}, 32'hFB);
        chk("slot2_cathode", {24'h0, cathode}, 32'h10);
      end
    end
    chk("en_lowmask", {24'h0, lowmask}, 32'h05);

    // Continuous request across three boundaries.
    #1 digit_en = 8'hFF; dp = 8'hAA; digits = 32'h0123ABCD; load_req = 1'b1;
    nacks = 0;
    while (cyc < 330) begin
      tick();
      if (load_ack) begin
        if (nacks < 4) ack_at[nacks] = cyc;
        nacks++;
        if (nacks == 3) #1 load_req = 1'b0;
      end
      if (cyc == 230) #1 digits = 32'h89ABCDEF;
    end
    chk("cont_acks", nacks, 3);
    if (nacks >= 3) begin
      chk("cont_first", ack_at[0], 224);
      chk("cont_gap1", ack_at[1] - ack_at[0], FRAME);
      chk("cont_gap2", ack_at[2] - ack_at[1], FRAME);
    end

    // Reset mid-slot and mid-handshake.
    wait_cyc(333);
    #1 load_req = 1'b1; digits = 32'h11111111;
    wait_cyc(342);
    chk("pre_rst_anode", {24'h0, anode}, 32'hDF);
    chk("pre_rst_cathode", {24'h0, cathode}, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_anode", {24'h0, anode}, 32'hFF);
    chk("async_cathode", {24'h0, cathode}, 32'hFF);
    chk("async_ack", {31'h0, load_ack}, 32'h0);
    repeat (2) tick();
    release_rst();
    wait_cyc(10);
    chk("cleared_anode", {24'h0, anode}, 32'hFF);
    wait_cyc(32);
    chk("post_rst_ack", {31'h0, load_ack}, 32'h1);
    #1 load_req = 1'b0;
    wait_cyc(34);
    chk("post_rst_anode", {24'h0, anode}, 32'hFE);
    chk("post_rst_cathode", {24'h0, cathode}, 32'h9F);
    wait_cyc(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clocks per digit slot (1 kHz per digit at 100 MHz); legal range 4 to 2^20.
REQ-002 Parameter BLANK_CYC, default 16, all-anodes-off cycles at the start of each slot; legal range 1 to REFRESH_DIV-1.
REQ-003 Ports: clk  in  1  system clock, single clock domain; all logic on rising edge.
REQ-004 Ports: rst_n  in  1  reset, asynchronous and active-low.
REQ-005 Ports: digits  in  32  eight hex nibbles; digits[4k+3:4k] is the value for digit k.
REQ-006 Ports: digit_en  in  8  per-digit enable; 0 forces that digit dark.
REQ-007 Ports: dp  in  8  per-digit decimal point; 1 means lit.
REQ-008 Ports: load_req  in  1  level request to latch digits, digit_en and dp.
REQ-009 Ports: load_ack  out  1  one-cycle pulse confirming the latch.
REQ-010 Ports: anode  out  8  active-low digit select; anode[k] drives digit k.
REQ-011 Ports: cathode  out  8  active-low segments, ordered {a,b,c,d,e,f,g,dp}; same encoding as the key/seed display ("1" = 8'b10011111, "0" = 8'b00000011).

Function
REQ-012 Prescaler cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; on wrap, slot index idx SHALL advance modulo 8 (7 -> 0).
REQ-013 Frame boundary SHALL be the cycle in which cnt wraps while idx==7.
REQ-014 Shadow registers SHALL hold digits/digit_en/dp; only the shadow copy drives the display.
REQ-015 If load_req is high at a frame boundary, the shadow SHALL capture the inputs on that edge and load_ack SHALL be high for exactly the following cycle; otherwise load_ack stays 0.
REQ-016 Requester SHALL hold data stable with load_req high until load_ack; if load_req is still high at the next boundary, a further capture and ack SHALL occur.
REQ-017 load_req sampled outside a frame boundary SHALL have no effect; no tearing within a frame.
REQ-018 anode and cathode SHALL be registered, one clock behind (idx, cnt).
REQ-019 While cnt < BLANK_CYC: anode = 8'hFF and cathode = 8'hFF.
REQ-020 While cnt >= BLANK_CYC: if shadow digit_en[idx]=0, anode = 8'hFF and cathode = 8'hFF; else anode = ~(8'h01 << idx), and cathode = decode(nibble idx) with bit 0 = ~dp[idx].
REQ-021 Decode SHALL map 0-9 to standard patterns and A-F to hex glyphs A,b,C,d,E,F; no invalid codes.
REQ-022 At most one anode bit SHALL be 0 in any cycle.

Reset
REQ-023 On rst_n low, immediately and independent of clk: cnt=0, idx=0, shadow digits=0, digit_en=0, dp=0, load_ack=0, anode=8'hFF, cathode=8'hFF.
REQ-024 A pending load_req SHALL be discarded by reset; the first capture after reset occurs at the first frame boundary, after 8*REFRESH_DIV cycles.
REQ-025 Reset asserted mid-slot or mid-handshake SHALL produce no ack and leave no partial shadow update.

Structure
REQ-026 Package seg_pkg SHALL hold the 16 nibble-to-cathode constants, CATH_OFF = 8'hFF, and ANODE_OFF = 8'hFF.
REQ-027 Sub-module seg_decode (combinational, nibble in, 7 segments out) SHALL be instantiated once; prescaler, idx, shadow and handshake logic remain in seg_scan.

Verification
Bench parameters for all scenarios: REFRESH_DIV=4, BLANK_CYC=1.
REQ-028 Scenario 1 (reset): after reset release, no load -> anode=8'hFF and cathode=8'hFF for 40 cycles; load_ack never high.
REQ-029 Scenario 2 (first load): load_req=1 from cycle 0 with digits=32'h76543210, digit_en=8'hFF, dp=0 -> load_ack pulses once, at the first frame boundary (cycle 32). In the next frame, slot 0 shows anode=8'hFE and cathode=8'b00000011; slot 1 shows anode=8'hFD and cathode=8'b10011111. Each slot is preceded by 1 blank cycle.
REQ-030 Scenario 3 (no tearing): change digits mid-frame with load_req=0 -> display unchanged. Then raise load_req -> new value appears only after the next boundary ack.
REQ-031 Scenario 4 (enable and dp): digit_en=8'b00000101, dp=8'b00000100 -> only anode bits 0 and 2 ever go low; slot 2 has cathode[0]=0 and slot 0 has cathode[0]=1.
REQ-032 Scenario 5 (mid-slot reset): assert rst_n low at cnt=2, idx=5 -> anode and cathode go to 8'hFF without waiting for a clock edge; after release, scan restarts at idx 0 with the shadow cleared.
REQ-033 Scenario 6 (continuous load): hold load_req high for 3 frames -> exactly 3 single-cycle acks spaced 32 cycles apart; one-cold anode checked every cycle.
